// File: rtl/lpf_acq_sequencer.sv
// Acquisition sequencer for a shift-programmable lowpass filter: clear, ramp the shift down, then hold lock.
// Optional lock watchdog enabled by defining LPF_ACQ_SEQUENCER_WATCHDOG_EN.
module lpf_acq_sequencer #(
    parameter int SHIFTBITS  = 4,
    parameter int SIGNALBITS = 14,
    parameter int DWELLBITS  = 24,
    parameter int WDBITS     = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [SHIFTBITS:0]           shift_start_i,
    input  logic [SHIFTBITS:0]           shift_final_i,
    input  logic [DWELLBITS-1:0]         dwell_i,
    input  logic signed [SIGNALBITS-1:0] error_i,
    input  logic [SIGNALBITS-2:0]        thresh_i,
    output logic [SHIFTBITS:0]           shift_o,
    output logic                         filter_on_o,
    output logic                         blk_rstn_o,
    output logic                         busy_o,
    output logic                         locked_o,
    output logic                         fault_o
);

    typedef enum logic [1:0] {IDLE, CLEAR, RAMP, LOCKED} state_t;

    state_t               state, state_next;
    logic [SHIFTBITS:0]   start_q, final_q, start_d, final_d, shift_d;
    logic [DWELLBITS-1:0] dwell_q, dwell_d, dwell_cnt, dwell_cnt_d;
    logic                 clr_cnt, clr_cnt_d;
    logic                 filter_on_d, blk_rstn_d, busy_d, locked_d;
    logic                 accept, dwell_done, wd_fire;

    assign accept     = (state == IDLE) && start_i && !abort_i;
    assign dwell_done = (dwell_cnt == DWELLBITS'(1));

`ifdef LPF_ACQ_SEQUENCER_WATCHDOG_EN
    localparam logic [SIGNALBITS-1:0] ERR_MIN = {1'b1, {(SIGNALBITS-1){1'b0}}};

    logic [SIGNALBITS-1:0] err_neg;
    logic [SIGNALBITS-2:0] err_mag;
    logic                  excursion;
    logic [WDBITS-1:0]     wd_cnt;
    logic                  fault_q;

    assign err_neg = '0 - $unsigned(error_i);

    // The most negative input has no positive twin; clamp it to full scale.
    always_comb begin
        if (!error_i[SIGNALBITS-1])
            err_mag = error_i[SIGNALBITS-2:0];
        else if ($unsigned(error_i) == ERR_MIN)
            err_mag = '1;
        else
            err_mag = err_neg[SIGNALBITS-2:0];
    end

    assign excursion = (err_mag > thresh_i);
    assign wd_fire   = (state == LOCKED) && excursion && (wd_cnt == '1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt  <= '0;
            fault_q <= 1'b0;
        end else begin
            if ((state == LOCKED) && excursion && !wd_fire)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (accept)
                fault_q <= 1'b0;
            else if (wd_fire && !abort_i)
                fault_q <= 1'b1;
        end
    end

    assign fault_o = fault_q;
`else
    logic unused_err;
    assign unused_err = ^{1'b0, error_i, thresh_i};
    assign wd_fire    = 1'b0;
    assign fault_o    = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            shift_o     <= '0;
            filter_on_o <= 1'b0;
            blk_rstn_o  <= 1'b0;
            busy_o      <= 1'b0;
            locked_o    <= 1'b0;
            start_q     <= '0;
            final_q     <= '0;
            dwell_q     <= '0;
            dwell_cnt   <= '0;
            clr_cnt     <= 1'b0;
        end else begin
            state       <= state_next;
            shift_o     <= shift_d;
            filter_on_o <= filter_on_d;
            blk_rstn_o  <= blk_rstn_d;
            busy_o      <= busy_d;
            locked_o    <= locked_d;
            start_q     <= start_d;
            final_q     <= final_d;
            dwell_q     <= dwell_d;
            dwell_cnt   <= dwell_cnt_d;
            clr_cnt     <= clr_cnt_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = CLEAR;
            CLEAR:   if (clr_cnt) state_next = RAMP;
            RAMP:    if (dwell_done && (shift_o == final_q)) state_next = LOCKED;
            LOCKED:  if (wd_fire) state_next = CLEAR;
            default: state_next = IDLE;
        endcase
        if (abort_i)
            state_next = IDLE;
    end

    // Registered outputs are decoded from the upcoming state so they change with it.
    always_comb begin
        shift_d     = shift_o;
        start_d     = start_q;
        final_d     = final_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt;
        clr_cnt_d   = 1'b0;

        if (accept) begin
            final_d = shift_final_i;
            start_d = (shift_start_i < shift_final_i) ? shift_final_i : shift_start_i;
            dwell_d = (dwell_i == '0) ? DWELLBITS'(1) : dwell_i;
        end

        if ((state == CLEAR) && (state_next == CLEAR))
            clr_cnt_d = 1'b1;

        if ((state == CLEAR) && (state_next == RAMP)) begin
            shift_d     = start_q;
            dwell_cnt_d = dwell_q;
        end else if ((state == RAMP) && (state_next == RAMP)) begin
            if (dwell_done) begin
                shift_d     = shift_o - 1'b1;
                dwell_cnt_d = dwell_q;
            end else begin
                dwell_cnt_d = dwell_cnt - 1'b1;
            end
        end else if (state_next != RAMP) begin
            dwell_cnt_d = '0;
        end

        filter_on_d = (state_next == RAMP) || (state_next == LOCKED);
        blk_rstn_d  = (state_next != CLEAR);
        busy_d      = (state_next == CLEAR) || (state_next == RAMP);
        locked_d    = (state_next == LOCKED);
    end

endmodule
